// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package riscv_mem_pkg;

  localparam int DATA_W        = 32;
  localparam int LANES         = DATA_W / 8;
  localparam int DEFAULT_DEPTH = 1024;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/riscv_mem_array.sv
// Byte-lane word storage: synchronous masked write, registered read strobed at commit.
module riscv_mem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] rdata
);

  genvar gi;
  generate
    // One RAM per byte lane so each lane's write enable stays independent.
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
        if (re) begin
          rdata_reg <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/riscv_mem_responder.sv
// MEM-stage load/store responder with programmable wait states.
// Define MEM_BYTE_MASK_EN to add the req_be byte-lane store mask.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_BYTE_MASK_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               we_reg;
  logic [DATA_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [LANES-1:0]   be_reg;
  logic               req_ready_reg;
  logic               rsp_valid_reg;
  logic               rsp_err_reg;
  logic               rsp_load_reg;
  logic               busy_reg;

  logic [LANES-1:0]   req_be_int;
  logic               accept;
  logic               commit;
  logic               acc_we;
  logic [DATA_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [LANES-1:0]   acc_be;
  logic               in_range;
  logic [DATA_W-1:0]  mem_rdata;

`ifdef MEM_BYTE_MASK_EN
  assign req_be_int = req_be;
`else
  assign req_be_int = '1;
`endif

  assign accept = req_valid && req_ready_reg;

  // With zero wait states the access commits on the accept edge straight from the request inputs.
  always_comb begin
    commit    = 1'b0;
    acc_we    = we_reg;
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    acc_be    = be_reg;
    if (state_reg == IDLE) begin
      commit    = accept && (WAIT_CYCLES == 0);
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be_int;
    end else if (state_reg == WAIT) begin
      commit = (cnt_reg == '0);
    end
  end

  assign in_range = (acc_addr < DATA_W'(DEPTH));

  riscv_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (commit && acc_we && in_range),
    .re    (commit && !acc_we && in_range),
    .addr  (acc_addr[AW-1:0]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_load_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg        <= req_we;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            be_reg        <= req_be_int;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_load_reg  <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (commit) begin
        rsp_err_reg  <= !in_range;
        rsp_load_reg <= !acc_we && in_range;
      end
    end
  end

  // The array read register has no reset, so gate it until a load has committed.
  assign rsp_rdata = rsp_load_reg ? mem_rdata : '0;
  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder with a scoreboard queue fed by a reference memory model.
// Three instances cover WAIT_CYCLES = 1, 3 and 0; byte-mask steps run when MEM_BYTE_MASK_EN is defined.
module tb_riscv_mem_responder;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];
  logic        busy      [NDUT];

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [int];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      riscv_mem_responder #(
        .DEPTH       (1024),
        .WAIT_CYCLES (gi == 0 ? 1 : (gi == 1 ? 3 : 0))
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
`ifdef MEM_BYTE_MASK_EN
        .req_be    (req_be[gi]),
`endif
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  function automatic int w_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
  endtask

  // Waits for the accept edge; when push is set, computes the expected response from the model.
  task automatic wait_accept(input int d, input bit push, output time t_acc);
    int          n;
    int          key;
    exp_t        e;
    logic [31:0] old;
    logic [31:0] mask;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", 32'(n < 50), 32'd1);
    @(posedge clk);
    t_acc = $time;
    if (push) begin
      e.d     = d;
      e.err   = (req_addr[d] >= 32'd1024);
      e.rdata = 32'h0;
      if (!e.err) begin
        key = d * 2048 + int'(req_addr[d]);
        old = model.exists(key) ? model[key] : 32'h0;
`ifdef MEM_BYTE_MASK_EN
        mask = {{8{req_be[d][3]}}, {8{req_be[d][2]}}, {8{req_be[d][1]}}, {8{req_be[d][0]}}};
`else
        mask = 32'hFFFF_FFFF;
`endif
        if (req_we[d]) model[key] = (old & ~mask) | (req_wdata[d] & mask);
        else           e.rdata = old;
      end
      sb.push_back(e);
    end
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[d] && lat < 50);
    chk("rsp_bound", 32'(rsp_valid[d]), 32'd1);
  endtask

  // Called at a negedge with rsp_valid high; compares against the scoreboard, then handshakes.
  task automatic take_rsp(input int d, input string tag, output time t_hs);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    last_rdata = rsp_rdata[d];
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata[d], e.rdata);
      chk({tag, "_err"}, 32'(rsp_err[d]), 32'(e.err));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    t_hs = $time;
    #1;
    chk({tag, "_valid_clear"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input string tag, output time t_acc);
    int  lat;
    time t_hs;
    present(d, we, addr, wdata, be);
    wait_accept(d, 1'b1, t_acc);
    wait_rsp(d, lat);
    chk({tag, "_latency"}, lat, w_of(d) + 1);
    take_rsp(d, tag, t_hs);
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[d], 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err[d]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    time ta;
    time tb2;
    time th;
    time prev;
    int  lat;

    rst_n = 1'b0;
    prev  = 0;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
      req_be[d]    = 4'hF;
      rsp_ready[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk_reset(d, "reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // WAIT_CYCLES=1: store then read back
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, "sw5", ta);
    txn(0, 1'b0, 32'd5, 32'h0, 4'hF, "lw5", ta);
    chk("lw5_value", last_rdata, 32'hDEAD_BEEF);

    // Out-of-range accesses must not disturb the top word
    txn(0, 1'b1, 32'd1023, 32'h1234_5678, 4'hF, "sw1023", ta);
    txn(0, 1'b0, 32'd1024, 32'h0, 4'hF, "lw1024", ta);
    txn(0, 1'b1, 32'hFFFF_FFFF, 32'h55AA_55AA, 4'hF, "swffff", ta);
    txn(0, 1'b0, 32'd1023, 32'h0, 4'hF, "lw1023", ta);
    chk("lw1023_value", last_rdata, 32'h1234_5678);

    // WAIT_CYCLES=3: response held under backpressure, queued request waits
    txn(1, 1'b1, 32'd10, 32'hCAFE_F00D, 4'hF, "sw10", ta);
    rsp_ready[1] = 1'b0;
    present(1, 1'b0, 32'd10, 32'h0, 4'hF);
    wait_accept(1, 1'b1, ta);
    present(1, 1'b1, 32'd11, 32'h0000_0077, 4'hF);
    wait_rsp(1, lat);
    chk("hold_latency", lat, 4);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[1]), 32'd1);
      chk("hold_rdata", rsp_rdata[1], 32'hCAFE_F00D);
      chk("hold_req_ready", 32'(req_ready[1]), 32'd0);
    end
    take_rsp(1, "lw10_held", th);
    wait_accept(1, 1'b1, tb2);
    chk("reaccept_gap", 32'(tb2 - th), 32'd10);
    wait_rsp(1, lat);
    take_rsp(1, "sw11", th);
    txn(1, 1'b0, 32'd11, 32'h0, 4'hF, "lw11", ta);
    chk("lw11_value", last_rdata, 32'h0000_0077);

    // WAIT_CYCLES=0: back-to-back stores, one accept every two cycles
    for (int i = 0; i < 4; i++) begin
      txn(2, 1'b1, 32'(i), 32'h1000_0000 + 32'(i), 4'hF, "b2b_sw", ta);
      if (i > 0) chk("b2b_gap", 32'(ta - prev), 32'd20);
      prev = ta;
    end
    for (int i = 0; i < 4; i++) begin
      txn(2, 1'b0, 32'(i), 32'h0, 4'hF, "b2b_lw", ta);
      chk("b2b_lw_value", last_rdata, 32'h1000_0000 + 32'(i));
    end

    // Reset during WAIT discards the captured store
    txn(1, 1'b1, 32'd7, 32'h0, 4'hF, "sw7_zero", ta);
    present(1, 1'b1, 32'd7, 32'h1, 4'hF);
    wait_accept(1, 1'b0, ta);
    @(negedge clk);
    chk("rst_pre_busy", 32'(busy[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(1, "midwait_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(1, 1'b0, 32'd7, 32'h0, 4'hF, "lw7_after_rst", ta);
    chk("lw7_value", last_rdata, 32'h0);

`ifdef MEM_BYTE_MASK_EN
    txn(0, 1'b1, 32'd9, 32'hAABB_CCDD, 4'hF, "be_full", ta);
    txn(0, 1'b1, 32'd9, 32'h1122_3344, 4'b0101, "be_0101", ta);
    txn(0, 1'b0, 32'd9, 32'h0, 4'hF, "be_lw1", ta);
    chk("be_merge_value", last_rdata, 32'hAA22_CC44);
    txn(0, 1'b1, 32'd9, 32'h0000_0000, 4'b0000, "be_none", ta);
    txn(0, 1'b0, 32'd9, 32'h0, 4'b0000, "be_lw2", ta);
    chk("be_noop_value", last_rdata, 32'hAA22_CC44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
